// File: rtl/pd_cell_read_if.sv
// Pointer-descriptor dequeue bus: pointer queue handshake, free-queue
// return, cell buffer read port and egress port stream, bundled so the
// dequeue engine and its environment share one connection.
//   master : the dequeue engine (pd_cell_read)
//   slave  : pointer memory control, cell buffer and egress ports
interface pd_cell_read_if #(
  parameter int NPORT  = 4,
  parameter int PTR_W  = 16,
  parameter int CELL_W = 128
);
  logic [NPORT-1:0]       pd_ptr_rdy;
  logic [NPORT-1:0]       pd_ptr_ack;
  logic [NPORT*PTR_W-1:0] pd_ptr_dout;
  logic                   pd_FQ_wr;
  logic [15:0]            pd_FQ_din;
  logic                   cell_rd_en;
  logic [8:0]             cell_rd_addr;
  logic [CELL_W-1:0]      cell_rd_data;
  logic [NPORT-1:0]       port_tx_valid;
  logic [NPORT-1:0]       port_tx_ready;
  logic [CELL_W-1:0]      port_tx_data;
  logic                   port_tx_last;

  modport master (
    input  pd_ptr_rdy, pd_ptr_dout, cell_rd_data, port_tx_ready,
    output pd_ptr_ack, pd_FQ_wr, pd_FQ_din, cell_rd_en, cell_rd_addr,
           port_tx_valid, port_tx_data, port_tx_last
  );

  modport slave (
    output pd_ptr_rdy, pd_ptr_dout, cell_rd_data, port_tx_ready,
    input  pd_ptr_ack, pd_FQ_wr, pd_FQ_din, cell_rd_en, cell_rd_addr,
           port_tx_valid, port_tx_data, port_tx_last
  );
endinterface

// File: rtl/pd_cell_read.sv
// Cell dequeue engine: round-robin picks a port with a queued frame, pops
// one pointer, reads the addressed cell, streams it to the port and returns
// the pointer to the free queue. A port is held (locked) until the pointer
// carrying the last-cell flag has been sent, so frames are never interleaved.
// Optional per-port frame counters: define PD_CELL_READ_STAT_EN.
module pd_cell_read #(
  parameter int NPORT   = 4,
  parameter int PTR_W   = 16,
  parameter int ACK_LAT = 1,
  parameter int CELL_W  = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  pd_cell_read_if.master         bus
`ifdef PD_CELL_READ_STAT_EN
  ,
  output logic [NPORT*16-1:0]    stat_frame_cnt
`endif
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [PW:0]   NP1       = (PW+1)'(NPORT);
  localparam logic [PW-1:0] LAST_PORT = PW'(NPORT - 1);
  localparam logic [7:0]    WAIT_LAST = 8'(ACK_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_WAIT, S_RD, S_CAP, S_TX, S_FREE
  } state_e;

  state_e              state_q;
  logic [PW-1:0]       rr_q;
  logic                lock_q;
  logic [PW-1:0]       g_q;
  logic [7:0]          wait_cnt_q;
  logic                ptr_last_q;
  logic [8:0]          ptr_addr_q;
  logic [NPORT-1:0]    ack_q;
  logic                fq_wr_q;
  logic [15:0]         fq_din_q;
  logic                rd_en_q;
  logic [8:0]          rd_addr_q;
  logic [NPORT-1:0]    tx_valid_q;
  logic [CELL_W-1:0]   tx_data_q;
  logic                tx_last_q;

  logic [NPORT-1:0]    cand_d;
  logic                gnt_found_d;
  logic [PW-1:0]       gnt_idx_d;
  logic                slice_last_d;
  logic [8:0]          slice_addr_d;

  function automatic logic [NPORT-1:0] onehot(input logic [PW-1:0] idx);
    logic [NPORT-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Candidate set and round-robin search starting at rr_q.
  always_comb begin
    logic [PW:0] sum;
    cand_d      = bus.pd_ptr_rdy;
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    if (lock_q) begin
      cand_d = bus.pd_ptr_rdy & onehot(g_q);
    end else begin
      cand_d = bus.pd_ptr_rdy;
    end
    for (int i = 0; i < NPORT; i++) begin
      sum = {1'b0, rr_q} + (PW+1)'(i);
      if (sum >= NP1) begin
        sum = sum - NP1;
      end else begin
        sum = sum;
      end
      if (!gnt_found_d && cand_d[sum[PW-1:0]]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = sum[PW-1:0];
      end else begin
        gnt_found_d = gnt_found_d;
      end
    end
  end

  // Head pointer fields of the granted port.
  always_comb begin
    slice_last_d = 1'b0;
    slice_addr_d = 9'd0;
    for (int p = 0; p < NPORT; p++) begin
      if (g_q == PW'(p)) begin
        slice_last_d = bus.pd_ptr_dout[p*PTR_W + 15];
        slice_addr_d = bus.pd_ptr_dout[p*PTR_W +: 9];
      end else begin
        slice_last_d = slice_last_d;
      end
    end
  end

  // Dequeue sequencer with registered strobes; reset drops any in-flight pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      g_q        <= '0;
      wait_cnt_q <= 8'd0;
      ptr_last_q <= 1'b0;
      ptr_addr_q <= 9'd0;
      ack_q      <= '0;
      fq_wr_q    <= 1'b0;
      fq_din_q   <= 16'd0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 9'd0;
      tx_valid_q <= '0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      rd_en_q <= 1'b0;
      fq_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found_d) begin
            g_q     <= gnt_idx_d;
            ack_q   <= onehot(gnt_idx_d);
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          wait_cnt_q <= 8'd0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            ptr_last_q <= slice_last_d;
            ptr_addr_q <= slice_addr_d;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= slice_addr_d;
            state_q    <= S_RD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          tx_data_q  <= bus.cell_rd_data;
          tx_valid_q <= onehot(g_q);
          tx_last_q  <= ptr_last_q;
          state_q    <= S_TX;
        end
        S_TX: begin
          if ((tx_valid_q & bus.port_tx_ready) != '0) begin
            tx_valid_q <= '0;
            tx_last_q  <= 1'b0;
            fq_wr_q    <= 1'b1;
            fq_din_q   <= {7'd0, ptr_addr_q};
            state_q    <= S_FREE;
          end
        end
        S_FREE: begin
          if (ptr_last_q) begin
            lock_q <= 1'b0;
            rr_q   <= (g_q == LAST_PORT) ? '0 : g_q + 1'b1;
          end else begin
            lock_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pd_ptr_ack    = ack_q;
  assign bus.pd_FQ_wr      = fq_wr_q;
  assign bus.pd_FQ_din     = fq_din_q;
  assign bus.cell_rd_en    = rd_en_q;
  assign bus.cell_rd_addr  = rd_addr_q;
  assign bus.port_tx_valid = tx_valid_q;
  assign bus.port_tx_data  = tx_data_q;
  assign bus.port_tx_last  = tx_last_q;

`ifdef PD_CELL_READ_STAT_EN
  logic [15:0] stat_q [NPORT];

  // Completed-frame counters, bumped when a last-cell pointer is freed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NPORT; p++) begin
        stat_q[p] <= 16'd0;
      end
    end else if ((state_q == S_FREE) && ptr_last_q) begin
      stat_q[g_q] <= stat_q[g_q] + 16'd1;
    end
  end

  // Flatten the counters onto the output bus, port p at [p*16+15:p*16].
  always_comb begin
    stat_frame_cnt = '0;
    for (int p = 0; p < NPORT; p++) begin
      stat_frame_cnt[p*16 +: 16] = stat_q[p];
    end
  end
`endif

endmodule
